// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue stage in front of the combinational 16-bit ALU. Commands are queued
//   in a small FIFO, launched one at a time into registered ALU operands, and
//   the ALU result is captured into an accumulator and returned with flags
//   over a valid/ready port.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (cmd_ready = FIFO not full)
//   cmd_op/a/b/use_acc       command payload
//   alu_a/alu_b/alu_sel      registered ALU drive
//   alu_result               combinational ALU output
//   out_valid/out_ready      result handshake
//   out_data + flags         result, zero, neg, carry/borrow, illegal opcode
//   acc                      accumulator
//   fifo_count               occupied FIFO entries
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | nothing in flight, waiting for the FIFO to fill
// EXEC  | ALU driven from alu_a/alu_b/alu_sel for one cycle
// DONE  | result presented on out_*, held until out_ready

module alu_issue_ctrl #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [3:0]                      cmd_op,
    input  logic [WIDTH-1:0]                cmd_a,
    input  logic [WIDTH-1:0]                cmd_b,
    input  logic                            cmd_use_acc,
    output logic [WIDTH-1:0]                alu_a,
    output logic [WIDTH-1:0]                alu_b,
    output logic [3:0]                      alu_sel,
    input  logic [WIDTH-1:0]                alu_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_zero,
    output logic                            out_neg,
    output logic                            out_carry,
    output logic                            out_err,
    output logic [WIDTH-1:0]                acc,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state, state_nxt;

    // ---------------- command FIFO ----------------
    logic [3:0]       f_op [FIFO_DEPTH];
    logic [WIDTH-1:0] f_a  [FIFO_DEPTH];
    logic [WIDTH-1:0] f_b  [FIFO_DEPTH];
    logic             f_ua [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             full, push, pop;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = cmd_valid && !full;
    assign pop       = (count != '0) &&
                       ((state == IDLE) || ((state == DONE) && out_ready));
    assign cmd_ready = !full;
    assign fifo_count = count;

    // Payload storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            f_op[wr_ptr] <= cmd_op;
            f_a[wr_ptr]  <= cmd_a;
            f_b[wr_ptr]  <= cmd_b;
            f_ua[wr_ptr] <= cmd_use_acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0) state_nxt = EXEC;
            EXEC: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = (count != '0) ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == DONE);
    end

    // ---------------- issue registers ----------------
    // acc only changes on the EXEC->DONE edge, so sampling it at the pop edge
    // gives the same value the command would see during EXEC.
    logic [3:0] op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            op_q    <= '0;
        end else if (pop) begin
            alu_a   <= f_ua[rd_ptr] ? acc : f_a[rd_ptr];
            alu_b   <= f_b[rd_ptr];
            alu_sel <= (f_op[rd_ptr] <= 4'd7) ? f_op[rd_ptr] : 4'd0;
            op_q    <= f_op[rd_ptr];
        end
    end

    // ---------------- result capture ----------------
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_carry, res_err;

    assign sum = {1'b0, alu_a} + {1'b0, alu_b};

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        case (op_q)
            4'd0: begin
                res       = alu_result;
                res_carry = (sum > (WIDTH+1)'({WIDTH{1'b1}}));
            end
            4'd1: begin
                res       = alu_result;
                res_carry = (alu_a < alu_b);
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: res = alu_result;
            4'd8:    res = alu_b;
            4'd9:    res = '0;
            default: res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
            acc       <= '0;
        end else if (state == EXEC) begin
            out_data  <= res;
            out_zero  <= (res == '0);
            out_neg   <= res[WIDTH-1];
            out_carry <= res_carry;
            out_err   <= res_err;
            if (!res_err) acc <= res;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic        cmd_use_acc = 1'b0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data, acc;
    logic        out_zero, out_neg, out_carry, out_err;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
        .out_err(out_err), .acc(acc), .fifo_count(fifo_count)
    );

    // external combinational ALU
    always_comb begin
        case (alu_sel)
            4'd0:    alu_result = alu_a + alu_b;
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a | alu_b;
            4'd3:    alu_result = alu_a & alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = ~(alu_a & alu_b);
            4'd6:    alu_result = ~(alu_a | alu_b);
            4'd7:    alu_result = ~alu_a;
            default: alu_result = 16'h0000;
        endcase
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ua;
    } cmd_t;

    cmd_t        mq[$];
    logic [15:0] macc = '0;
    int          n_cmp = 0, n_err = 0;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d = '0;
    logic        ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: commands complete strictly in acceptance order.
    task automatic check_result();
        cmd_t        c;
        logic [16:0] s;
        logic [15:0] a, r;
        logic        cy, er;
        if (mq.size() == 0) begin
            chk("spurious_result", 32'd1, 32'd0);
            return;
        end
        c  = mq.pop_front();
        a  = c.ua ? macc : c.a;
        cy = 1'b0;
        er = 1'b0;
        r  = 16'h0000;
        case (c.op)
            4'd0: begin s = {1'b0, a} + {1'b0, c.b}; r = s[15:0]; cy = s[16]; end
            4'd1: begin r = a - c.b; cy = (a < c.b); end
            4'd2: r = a | c.b;
            4'd3: r = a & c.b;
            4'd4: r = a ^ c.b;
            4'd5: r = ~(a & c.b);
            4'd6: r = ~(a | c.b);
            4'd7: r = ~a;
            4'd8: r = c.b;
            4'd9: r = 16'h0000;
            default: er = 1'b1;
        endcase
        if (!er) macc = r;
        chk("out_data", out_data, r);
        chk("out_zero", out_zero, r == 16'h0000);
        chk("out_neg", out_neg, r[15]);
        chk("out_carry", out_carry, cy);
        chk("out_err", out_err, er);
        chk("acc", acc, macc);
    endtask

    task automatic cyc(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic ua, input logic ordy,
                       output logic accepted);
        cmd_valid   = v;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        out_ready   = ordy;
        accepted    = v && cmd_ready;
        if (hold_v && out_valid) chk("hold_data", out_data, hold_d);
        hold_v = out_valid && !ordy;
        hold_d = out_data;
        if (out_valid && ordy) check_result();
        if (accepted) mq.push_back('{op, a, b, ua});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || out_valid) && n < 100) begin
            cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, ok);
            n++;
        end
        chk("drain_left", mq.size(), 0);
    endtask

    task automatic post_reset();
        mq.delete();
        macc   = '0;
        hold_v = 1'b0;
    endtask

    initial begin
        int lat, nacc, guard;
        logic [3:0] rop;
        logic [15:0] ra, rb;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc", acc, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_alu", {alu_a, alu_b}, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_out", {out_data, out_zero, out_neg, out_carry, out_err}, 0);
        rst = 1'b0;
        post_reset();

        // ADD with carry, latency
        cyc(1'b1, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, ok);
        chk("t1_accept", ok, 1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, ok);
            lat++;
        end
        chk("t1_latency", lat, 2);
        drain();

        // LOAD then AND using acc
        cyc(1'b1, 4'd8, 16'h0000, 16'h1234, 1'b0, 1'b1, ok);
        cyc(1'b1, 4'd3, 16'hFFFF, 16'h00FF, 1'b1, 1'b1, ok);
        drain();
        chk("t2_acc", acc, 16'h0034);

        // SUB with borrow
        cyc(1'b1, 4'd1, 16'h0003, 16'h0005, 1'b0, 1'b1, ok);
        drain();

        // FIFO full with out_ready low
        nacc = 0;
        guard = 0;
        while (nacc < 5 && guard < 20) begin
            cyc(1'b1, 4'(nacc), 16'(16'h0100 + nacc), 16'(nacc + 1), 1'b0, 1'b0, ok);
            if (ok) nacc++;
            guard++;
        end
        chk("t4_accepts", nacc, 5);
        chk("t4_fifo_count", fifo_count, 4);
        chk("t4_cmd_ready", cmd_ready, 0);
        cyc(1'b1, 4'd0, 16'h1, 16'h1, 1'b0, 1'b0, ok);
        chk("t4_no_push_full", ok, 0);
        drain();

        // illegal opcode leaves acc untouched
        cyc(1'b1, 4'd8, 16'h0000, 16'h0055, 1'b0, 1'b1, ok);
        cyc(1'b1, 4'hC, 16'h1111, 16'h2222, 1'b1, 1'b1, ok);
        cyc(1'b1, 4'd2, 16'h0000, 16'h0100, 1'b1, 1'b1, ok);
        drain();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            cyc(1'($urandom_range(0, 1)), rop, ra, rb, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), ok);
        end
        drain();

        // async reset while holding a result in DONE
        cyc(1'b1, 4'd9, 16'h0, 16'h0, 1'b0, 1'b0, ok);
        cyc(1'b1, 4'd8, 16'h0, 16'hBEEF, 1'b0, 1'b0, ok);
        cyc(1'b1, 4'd0, 16'h1, 16'h1, 1'b0, 1'b0, ok);
        guard = 0;
        while (!out_valid && guard < 10) begin
            cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, ok);
            guard++;
        end
        chk("t6_in_done", out_valid, 1);
        cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, ok);
        guard = 0;
        while (!out_valid && guard < 10) begin
            cyc(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, ok);
            guard++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_acc", acc, 0);
        chk("t6_fifo_count", fifo_count, 0);
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        post_reset();
        cyc(1'b1, 4'd0, 16'h0002, 16'h0003, 1'b0, 1'b1, ok);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
